class_similarity_search: RTL
============================

Name: class_similarity_search

Overview:
- Associative-search stage directly downstream of the class hypervector generator.
- Buffers one query hypervector, delivered as NUM_FRAMES frames of FRAME_WIDTH bits.
- Walks the generator through every (class, frame) address and accumulates the Hamming distance per class.
- Reports the class with minimum distance over a valid/ready result handshake to the classification output logic.

Parameters:
- FRAME_WIDTH, 64, bits per hypervector frame.
- NUM_FRAMES, 3, frames per hypervector.
- NUM_CLASSES, 8, number of classes searched.
- CLASS_ID_W, 3, width of class id / frame_id; must be at least clog2(NUM_CLASSES).
- FRAME_IDX_W, 2, width of frame_index; must be at least clog2(NUM_FRAMES).
- DIST_W, 8, distance width; must be at least clog2(FRAME_WIDTH*NUM_FRAMES+1).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- query_frame_in  in  FRAME_WIDTH  query frame; frame 0 first.
- query_valid  in  1  query frame valid.
- query_ready  out  1  block accepts a query frame this cycle.
- frame_id  out  CLASS_ID_W  class address to generator.
- frame_index  out  FRAME_IDX_W  frame address to generator.
- class_vec_in  in  FRAME_WIDTH  generator output for the current address (combinational, same cycle).
- busy  out  1  high in SEARCH or DRAIN.
- result_class  out  CLASS_ID_W  winning class.
- result_dist  out  DIST_W  Hamming distance of the winning class.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts the result.

Behaviour:
- Reset, asynchronous while rst_n=0:
  - state=LOAD; all counters, accumulators and query buffer cleared.
  - query_ready=1 once in LOAD.
  - frame_id=0, frame_index=0, busy=0.
  - result_class=0, result_dist=0, result_valid=0.
- Reset mid-operation discards any partial query or search; no result is produced.
- LOAD:
  - query_ready=1.
  - A beat is accepted when query_valid && query_ready; it is stored in buffer slot load_cnt, and load_cnt increments.
  - On acceptance of beat NUM_FRAMES-1: load_cnt←0, go to SEARCH next cycle.
- SEARCH, query_ready=0:
  - Step counter k runs 0..NUM_CLASSES*NUM_FRAMES-1, one step per cycle, with no stalls.
  - frame_id=k/NUM_FRAMES and frame_index=k%NUM_FRAMES, driven from registered counters (class counter, frame counter; frame wraps NUM_FRAMES-1→0 and increments class).
  - Stage 1, each cycle: pc = popcount(query_buf[frame_index] XOR class_vec_in) is registered together with its class id and a last-frame flag.
  - After the final step, go to DRAIN.
- Stage 2, the cycle after stage 1:
  - sum = acc + pc.
  - If the flag is not last: acc←sum.
  - If the flag is last, acc←0, then compare:
    - For the first class, or when sum < best_dist strictly: best_dist←sum, best_class←id.
    - Ties keep the lower class index.
- DRAIN: one cycle, in which stage 2 processes the final frame. Then go to DONE.
- DONE:
  - result_valid=1; result_class/result_dist = best values, held stable until handshake.
  - On result_valid && result_ready: result_valid←0 next cycle, state←LOAD.
  - query_ready=0 in DONE; a new query is accepted no earlier than the cycle after the result handshake.
- Latency: result_valid rises NUM_CLASSES*NUM_FRAMES+1 cycles after the first SEARCH cycle (25 with defaults).
- frame_id and frame_index are held at 0 outside SEARCH.
- Arithmetic:
  - The accumulator is DIST_W bits and cannot overflow, since the maximum is FRAME_WIDTH*NUM_FRAMES = 192.
  - popcount is zero-extended to DIST_W.
- query_valid asserted outside LOAD is ignored (no acceptance).
- result_ready asserted while result_valid=0 has no effect.

Test Plan:
- Use the real generator, with the query equal to the three frames of class 3. Required: result_class=3, result_dist=0, result_valid exactly 25 cycles after the first SEARCH cycle.
- Use the real generator, with the query equal to class 5 frames with 7 bits flipped in frame 1. Required: result_class=5, result_dist=7.
- Use a stub generator returning all-zero frames for every class, with query frames each containing 10 ones. Required: result_class=0 (tie rule), result_dist=30.
- Use a stub generator where class c returns frames with popcount 20-2c, with an all-zero query. Required: result_class=7, result_dist=18; frame_id/frame_index sequence (0,0),(0,1),(0,2),(1,0)…(7,2) with no gaps.
- Hold result_ready=0 for 10 cycles in DONE while query_valid=1. Required: result_valid and result values stable, query_ready=0, no beat accepted. After the handshake, the next query loads normally.
- Assert rst_n=0 mid-SEARCH (k=11). Required: outputs return to reset values immediately, state LOAD, no result_valid. A fresh query afterward gives the correct result.

Source files
------------

// File: rtl/class_similarity_search.sv
// Associative search: buffers one query hypervector, walks the class generator over every
// (class, frame) address, accumulates Hamming distance per class and reports the nearest class.
`timescale 1ns/1ps
module class_similarity_search #(
    parameter int FRAME_WIDTH = 64,
    parameter int NUM_FRAMES  = 3,
    parameter int NUM_CLASSES = 8,
    parameter int CLASS_ID_W  = 3,
    parameter int FRAME_IDX_W = 2,
    parameter int DIST_W      = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [FRAME_WIDTH-1:0] query_frame_in,
    input  logic                   query_valid,
    output logic                   query_ready,
    output logic [CLASS_ID_W-1:0]  frame_id,
    output logic [FRAME_IDX_W-1:0] frame_index,
    input  logic [FRAME_WIDTH-1:0] class_vec_in,
    output logic                   busy,
    output logic [CLASS_ID_W-1:0]  result_class,
    output logic [DIST_W-1:0]      result_dist,
    output logic                   result_valid,
    input  logic                   result_ready
);

    typedef enum logic [1:0] {LOAD, SEARCH, DRAIN, DONE} state_t;

    localparam logic [FRAME_IDX_W-1:0] LAST_FRAME = FRAME_IDX_W'(NUM_FRAMES - 1);
    localparam logic [CLASS_ID_W-1:0]  LAST_CLASS = CLASS_ID_W'(NUM_CLASSES - 1);

    state_t                 state, state_next;
    logic [FRAME_WIDTH-1:0] query_buf [NUM_FRAMES];
    logic [FRAME_IDX_W-1:0] load_cnt;
    logic [CLASS_ID_W-1:0]  class_cnt;
    logic [FRAME_IDX_W-1:0] frame_cnt;
    logic                   s1_valid;
    logic                   s1_last;
    logic [CLASS_ID_W-1:0]  s1_id;
    logic [DIST_W-1:0]      s1_pc;
    logic [DIST_W-1:0]      acc;
    logic [DIST_W-1:0]      sum;
    logic [DIST_W-1:0]      best_dist;
    logic [CLASS_ID_W-1:0]  best_class;
    logic                   beat_accept;
    logic                   last_step;

    function automatic logic [DIST_W-1:0] popcount(input logic [FRAME_WIDTH-1:0] v);
        logic [DIST_W-1:0] n;
        n = '0;
        for (int i = 0; i < FRAME_WIDTH; i++) n = n + DIST_W'(v[i]);
        return n;
    endfunction

    assign query_ready  = (state == LOAD);
    assign busy         = (state == SEARCH) || (state == DRAIN);
    assign result_valid = (state == DONE);
    assign result_class = best_class;
    assign result_dist  = best_dist;
    assign frame_id     = (state == SEARCH) ? class_cnt : '0;
    assign frame_index  = (state == SEARCH) ? frame_cnt : '0;
    assign beat_accept  = query_valid && query_ready;
    assign last_step    = (class_cnt == LAST_CLASS) && (frame_cnt == LAST_FRAME);
    assign sum          = acc + s1_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            LOAD:    if (beat_accept && load_cnt == LAST_FRAME) state_next = SEARCH;
            SEARCH:  if (last_step) state_next = DRAIN;
            DRAIN:   state_next = DONE;
            DONE:    if (result_ready) state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_FRAMES; i++) query_buf[i] <= '0;
            load_cnt   <= '0;
            class_cnt  <= '0;
            frame_cnt  <= '0;
            s1_valid   <= 1'b0;
            s1_last    <= 1'b0;
            s1_id      <= '0;
            s1_pc      <= '0;
            acc        <= '0;
            best_dist  <= '0;
            best_class <= '0;
        end else begin
            if (beat_accept) begin
                query_buf[load_cnt] <= query_frame_in;
                load_cnt <= (load_cnt == LAST_FRAME) ? '0 : load_cnt + 1'b1;
            end

            // Address counters double as the generator address; they wrap back to 0 after the last step.
            if (state == SEARCH) begin
                if (frame_cnt == LAST_FRAME) begin
                    frame_cnt <= '0;
                    class_cnt <= (class_cnt == LAST_CLASS) ? '0 : class_cnt + 1'b1;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end

            s1_valid <= (state == SEARCH);
            s1_pc    <= popcount(query_buf[frame_cnt] ^ class_vec_in);
            s1_id    <= class_cnt;
            s1_last  <= (frame_cnt == LAST_FRAME);

            // Class 0 always seeds the best; strict compare keeps the lower index on ties.
            if (s1_valid) begin
                if (!s1_last) begin
                    acc <= sum;
                end else begin
                    acc <= '0;
                    if (s1_id == '0 || sum < best_dist) begin
                        best_dist  <= sum;
                        best_class <= s1_id;
                    end
                end
            end
        end
    end

endmodule
